instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Encoder counterpart of the main control decoder. Takes instruction descriptions (class plus fields) over a valid/ready stream, assembles 32-bit MIPS words using the datapath opcode map, and writes them to consecutive instruction-memory addresses.
- Loads test programs into the instruction memory before the datapath runs.

Parameters:
- ADDR_W, 8, word-address width of the instruction memory; capacity is 2^ADDR_W words.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a load session.
- in_valid  input  1  instruction beat valid.
- in_ready  output  1  loader accepts a beat this cycle.
- in_last  input  1  marks the final beat of the program.
- in_kind  input  4  class: 0 R-type, 1 lw, 2 sw, 3 beq, 4 bne, 5 bgtz, 6 addi, 7 subi, 8 andi, 9 ori, 10 slti; 11-15 are illegal.
- in_rs, in_rt, in_rd, in_shamt  input  5 each  register and shift fields.
- in_funct  input  6  R-type function field.
- in_imm  input  16  immediate or branch offset.
- mem_we  output  1  instruction-memory write strobe.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  32  encoded instruction.
- count  output  ADDR_W+1  words written this session.
- busy  output  1  high in LOAD.
- done  output  1  one-cycle pulse at session end.
- err  output  1  sticky: an illegal kind was seen this session.

Behaviour:
- Reset: state IDLE; in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, busy=0, done=0, err=0.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, bgtz 000111, addi 001000, subi 001001, andi 001100, ori 001101, slti 001010.
- R-type word: {000000, rs, rt, rd, shamt, funct}.
- I-type word: {op, rs, rt, imm}; bgtz forces rt=00000. in_rd, in_shamt and in_funct are ignored for I-type.
- States and transitions:
  - IDLE: in_ready=0. start moves to LOAD; mem_addr=BASE_ADDR, count=0, err=0.
  - LOAD: busy=1. in_ready=1 unless a write is pending to the last memory address. A beat is accepted when in_valid and in_ready are both high.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Write latency: an accepted legal beat produces mem_we=1 exactly one cycle later, with mem_wdata set to the encoded word and mem_addr set to the current pointer. The pointer and count increment in that write cycle.
- Back-to-back: one beat accepted per cycle. Writes stream at one word per cycle with consecutive addresses.
- Illegal kind: the beat is consumed and nothing is written. Pointer and count are unchanged. err is set and held until the next start.
- in_last on an accepted beat: in_ready drops the next cycle. After the final write cycle (or immediately, if that beat was illegal), the FSM enters DONE.
- Full: after writing address 2^ADDR_W-1, enter DONE even without in_last. No beat is accepted while that final write is pending.
- start while in LOAD or DONE is ignored.
- in_valid while in IDLE is ignored; no state change.
- No wrap-around: mem_addr never exceeds 2^ADDR_W-1 within a session.
- Reset mid-session: immediate return to reset values. A pending write is dropped, and mem_we goes low asynchronously.
- mem_wdata holds its last value when mem_we=0.

Test Plan:
- Reset, then start; beat R-type rs=1, rt=2, rd=3, shamt=0, funct=100000 with in_last -> one cycle later mem_we=1, addr=0, wdata=0x00221820; next cycle done=1; count=1.
- Stream lw rs=0 rt=8 imm=4, sw rs=0 rt=8 imm=8, then beq rs=8 rt=9 imm=0xFFFF (last), back-to-back -> writes at addrs 0, 1, 2 on consecutive cycles: 0x8C080004, 0xAC080008, 0x1109FFFF; done one cycle after the last write.
- bgtz rs=4 rt=7 imm=3 -> wdata=0x1C800003 (rt forced to 0); slti rs=1 rt=2 imm=0x8000 -> 0x28228000.
- Beat kind=12, then addi rs=0 rt=1 imm=5 (last) -> no write for the first beat; err=1; addi written at addr 0 as 0x20010005; count=1; next start clears err.
- ADDR_W=2, BASE_ADDR=0, four beats without in_last while in_valid stays high -> writes to addrs 0-3; in_ready=0 after the fourth acceptance; done pulses; a fifth beat is not accepted.
- Assert rst_n=0 on the cycle after a beat is accepted -> no mem_we; all outputs at reset values; IDLE.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes instruction descriptions into MIPS words and streams them into instruction memory
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} stateType;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  stateType state;
  logic lastSeen, accept, legal, writeNext, lastNext, stop;
  logic [ADDR_W-1:0] target;
  logic [5:0] opcode;
  logic [31:0] word;
  always_comb begin
    accept = state == LOAD && in_valid && in_ready;
    legal = in_kind <= 4'd10;
    writeNext = accept && legal;
    lastNext = lastSeen || (accept && in_last);
    target = mem_we ? mem_addr + ADDR_W'(1) : mem_addr;
    stop = (mem_we && mem_addr == LAST_ADDR) || (lastNext && !writeNext);
    case (in_kind)
      4'd1:    opcode = 6'b100011;
      4'd2:    opcode = 6'b101011;
      4'd3:    opcode = 6'b000100;
      4'd4:    opcode = 6'b000101;
      4'd5:    opcode = 6'b000111;
      4'd6:    opcode = 6'b001000;
      4'd7:    opcode = 6'b001001;
      4'd8:    opcode = 6'b001100;
      4'd9:    opcode = 6'b001101;
      4'd10:   opcode = 6'b001010;
      default: opcode = 6'b000000;
    endcase
    word = in_kind == 4'd0 ? {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct}
                           : {opcode, in_rs, in_kind == 4'd5 ? 5'd0 : in_rt, in_imm};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= BASE_ADDR;
      mem_wdata <= '0;
      count <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      lastSeen <= 1'b0;
    end else begin
      done <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          in_ready <= 1'b1;
          busy <= 1'b1;
          mem_addr <= BASE_ADDR;
          count <= '0;
          err <= 1'b0;
          lastSeen <= 1'b0;
        end
        LOAD: begin
          mem_we <= writeNext;
          if (writeNext) mem_wdata <= word;
          if (accept && !legal) err <= 1'b1;
          lastSeen <= lastNext;
          // pointer advances in the write cycle but parks on the last address
          if (mem_we) begin
            count <= count + (ADDR_W+1)'(1);
            if (mem_addr != LAST_ADDR) mem_addr <= mem_addr + ADDR_W'(1);
          end
          in_ready <= !stop && !lastNext && !(writeNext && target == LAST_ADDR);
          if (stop) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: randomized sessions checked against a queue-based reference model
module tb_instr_encoder_loader;
  localparam int AW = 3;
  localparam int CAP = 1 << AW;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, in_last = 0, in_ready;
  logic [3:0] in_kind = 0;
  logic [4:0] in_rs = 0, in_rt = 0, in_rd = 0, in_shamt = 0;
  logic [5:0] in_funct = 0;
  logic [15:0] in_imm = 0;
  logic mem_we, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [AW:0] count;
  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(3'd0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, passes = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask
  function automatic logic [31:0] enc(input logic [3:0] k, input logic [4:0] rs, rt, rd, sh,
                                      input logic [5:0] fn, input logic [15:0] imm);
    logic [5:0] ops [11] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h07, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0A};
    return k == 0 ? {6'h00, rs, rt, rd, sh, fn} : {ops[k], rs, k == 5 ? 5'd0 : rt, imm};
  endfunction
  logic [31:0] expWord [$];
  int expAddr [$], expCyc [$];
  int doneTotal = 0, doneAt = -1;
  always @(negedge clk) if (rst_n) begin
    if (done) begin doneTotal++; doneAt = cyc; end
    if (mem_we) begin
      if (expWord.size() == 0) check("spurious_we", 1, 0);
      else begin
        check("wdata", mem_wdata, expWord.pop_front());
        check("waddr", 64'(mem_addr), 64'(expAddr.pop_front()));
        check("wcycle", 64'(cyc), 64'(expCyc.pop_front()));
      end
    end
  end
  int mNwr, mLastAcc, doneBase;
  bit mErr, mEnded, mLastLegal;
  task automatic startSession();
    mNwr = 0; mErr = 0; mEnded = 0; doneBase = doneTotal;
    start = 1;
    @(negedge clk);
    start = 0;
    check("start_busy", busy, 1);
    check("start_ready", in_ready, 1);
    check("start_err", err, 0);
    check("start_count", count, 0);
  endtask
  task automatic beat(input logic [3:0] k, input logic [4:0] rs, rt, rd, sh,
                      input logic [5:0] fn, input logic [15:0] imm, input bit last);
    int w = 0;
    in_valid = 1; in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_funct = fn; in_imm = imm; in_last = last;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      mEnded = 1;
    end else begin
      if (k <= 10) begin
        expWord.push_back(enc(k, rs, rt, rd, sh, fn, imm));
        expAddr.push_back(mNwr);
        expCyc.push_back(cyc + 1);
        mNwr++;
      end else mErr = 1;
      mLastAcc = cyc;
      mLastLegal = k <= 10;
      mEnded = last || mNwr == CAP;
    end
    @(negedge clk);
    in_valid = 0; in_last = 0;
    if (mEnded) check("ready_drop", in_ready, 0);
  endtask
  task automatic endSession();
    in_valid = 1; in_kind = 4'd6; in_last = 0;
    repeat (6) begin
      check("idle_ready", in_ready, 0);
      @(negedge clk);
    end
    in_valid = 0;
    check("done_pulses", 64'(doneTotal - doneBase), 1);
    check("done_cycle", 64'(doneAt), 64'(mLastAcc + (mLastLegal ? 2 : 1)));
    check("end_count", 64'(count), 64'(mNwr));
    check("end_err", err, mErr);
    check("end_busy", busy, 0);
    check("pending_writes", 64'(expWord.size()), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", 64'(mem_addr), 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1;
    @(negedge clk);
    startSession();
    beat(0, 1, 2, 3, 0, 6'b100000, 0, 1);
    endSession();
    startSession();
    beat(1, 0, 8, 0, 0, 0, 16'h0004, 0);
    beat(2, 0, 8, 0, 0, 0, 16'h0008, 0);
    beat(3, 8, 9, 0, 0, 0, 16'hFFFF, 1);
    endSession();
    startSession();
    beat(5, 4, 7, 0, 0, 0, 16'h0003, 0);
    beat(10, 1, 2, 0, 0, 0, 16'h8000, 1);
    endSession();
    startSession();
    beat(12, 3, 3, 3, 3, 3, 16'h1234, 0);
    beat(6, 0, 1, 0, 0, 0, 16'h0005, 1);
    endSession();
    startSession();
    for (int i = 0; i < CAP + 2 && !mEnded; i++) beat(4'(i % 11), 5'(i), 5'(i + 1), 5'(i + 2), 0, 6'(i), 16'(i * 3), 0);
    endSession();
    for (int s = 0; s < 40; s++) begin
      startSession();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n && !mEnded; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        beat(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             6'($urandom), 16'($urandom), i == n - 1);
      end
      endSession();
    end
    startSession();
    in_valid = 1; in_kind = 4'd1; in_rs = 5'd2; in_rt = 5'd3; in_imm = 16'h00AA; in_last = 0;
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("midrst_we", mem_we, 0);
    check("midrst_ready", in_ready, 0);
    check("midrst_addr", 64'(mem_addr), 0);
    check("midrst_wdata", mem_wdata, 0);
    check("midrst_count", count, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_err", err, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (4) begin
      @(negedge clk);
      check("postrst_ready", in_ready, 0);
      check("postrst_busy", busy, 0);
    end
    in_valid = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
